// File: rtl/power_alu_pkg.sv
// Shared definitions for the power_alu accumulator ALU: default width and opcode encoding.
// Optional status flags are enabled by defining POWER_ALU_FLAGS_EN.
package power_alu_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [3:0] {
      OP_PASS = 4'b0000,
      OP_INC  = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SUB  = 4'b0011,
      OP_DEC  = 4'b0100,
      OP_NOT  = 4'b0101,
      OP_AND  = 4'b0110,
      OP_NAND = 4'b0111,
      OP_OR   = 4'b1000,
      OP_NOR  = 4'b1001,
      OP_XOR  = 4'b1010,
      OP_XNOR = 4'b1011,
      OP_GT   = 4'b1100,
      OP_LT   = 4'b1101,
      OP_EQ   = 4'b1110,
      OP_LNOT = 4'b1111
   } op_e;

   // Opcodes that go through the shared adder and therefore produce carry/overflow.
   function automatic logic is_arith(input op_e op);
      return (op == OP_INC) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_DEC);
   endfunction

endpackage

// File: rtl/power_alu_core.sv
// Combinational next-result logic for power_alu: computes f(opcode, a, b).
// With POWER_ALU_FLAGS_EN defined it also produces zero/neg/carry/ovf for the next result.
module power_alu_core
   import power_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef POWER_ALU_FLAGS_EN
   output logic             zero_nxt,
   output logic             neg_nxt,
   output logic             carry_nxt,
   output logic             ovf_nxt,
`endif
   output logic [WIDTH-1:0] b_nxt
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   op_e              op;
   logic [WIDTH-1:0] arith_y;
   logic             arith_sub;
   logic [WIDTH:0]   arith_sum;
   logic [WIDTH-1:0] arith_res;
   logic             arith_cout;
   logic             arith_ovf;

   assign op = op_e'(opcode);

   // One adder serves inc/add/sub/dec: second operand is b or 1, subtract via a + ~y + 1.
   always_comb begin
      arith_y   = ONE;
      arith_sub = 1'b0;
      case (op)
         OP_ADD:  arith_y = b;
         OP_SUB:  begin arith_y = b; arith_sub = 1'b1; end
         OP_DEC:  arith_sub = 1'b1;
         default: ;
      endcase
   end

   assign arith_sum  = {1'b0, a} + {1'b0, (arith_sub ? ~arith_y : arith_y)}
                       + {{WIDTH{1'b0}}, arith_sub};
   assign arith_res  = arith_sum[WIDTH-1:0];
   // For subtraction the adder carry is the inverse of borrow.
   assign arith_cout = arith_sub ? ~arith_sum[WIDTH] : arith_sum[WIDTH];
   assign arith_ovf  = arith_sub
                       ? ((a[WIDTH-1] != arith_y[WIDTH-1]) && (arith_res[WIDTH-1] != a[WIDTH-1]))
                       : ((a[WIDTH-1] == arith_y[WIDTH-1]) && (arith_res[WIDTH-1] != a[WIDTH-1]));

   always_comb begin
      b_nxt = '0;
      case (op)
         OP_PASS: b_nxt = a;
         OP_INC,
         OP_ADD,
         OP_SUB,
         OP_DEC:  b_nxt = arith_res;
         OP_NOT:  b_nxt = ~a;
         OP_AND:  b_nxt = a & b;
         OP_NAND: b_nxt = ~(a & b);
         OP_OR:   b_nxt = a | b;
         OP_NOR:  b_nxt = ~(a | b);
         OP_XOR:  b_nxt = a ^ b;
         OP_XNOR: b_nxt = ~(a ^ b);
         OP_GT:   b_nxt = ($signed(a) > $signed(b)) ? ONE : '0;
         OP_LT:   b_nxt = ($signed(a) < $signed(b)) ? ONE : '0;
         OP_EQ:   b_nxt = (a == b) ? ONE : '0;
         OP_LNOT: b_nxt = (a == '0) ? ONE : '0;
         default: b_nxt = '0;
      endcase
   end

`ifdef POWER_ALU_FLAGS_EN
   assign zero_nxt  = (b_nxt == '0);
   assign neg_nxt   = b_nxt[WIDTH-1];
   assign carry_nxt = is_arith(op) ? arith_cout : 1'b0;
   assign ovf_nxt   = is_arith(op) ? arith_ovf  : 1'b0;
`endif

endmodule

// File: rtl/power_alu.sv
// power_alu top: result register b (fed back as operand B) plus optional flag registers.
// Define POWER_ALU_FLAGS_EN to add the zero/neg/carry/ovf outputs.
module power_alu
   import power_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
`ifdef POWER_ALU_FLAGS_EN
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] b
);

   // No handshake: an operation is accepted on every rising edge and its
   // result appears on b after that same edge.
   logic [WIDTH-1:0] b_nxt;
`ifdef POWER_ALU_FLAGS_EN
   logic zero_nxt, neg_nxt, carry_nxt, ovf_nxt;
`endif

   power_alu_core #(.WIDTH(WIDTH)) u_core (
      .opcode    (opcode),
      .a         (a),
      .b         (b),
`ifdef POWER_ALU_FLAGS_EN
      .zero_nxt  (zero_nxt),
      .neg_nxt   (neg_nxt),
      .carry_nxt (carry_nxt),
      .ovf_nxt   (ovf_nxt),
`endif
      .b_nxt     (b_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b <= '0;
      end else begin
         b <= b_nxt;
      end
   end

`ifdef POWER_ALU_FLAGS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero  <= 1'b0;
         neg   <= 1'b0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         zero  <= zero_nxt;
         neg   <= neg_nxt;
         carry <= carry_nxt;
         ovf   <= ovf_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_power_alu.sv
// Directed bench for power_alu: driver pushes hand-computed results into exp_q,
// a monitor pops one entry per issued edge and compares it with b.
module tb_power_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   opcode = 4'b0000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b;
`ifdef POWER_ALU_FLAGS_EN
   logic zero, neg, carry, ovf;
`endif

   logic [W-1:0] exp_q[$];
   logic         issue = 1'b0;
   int           n_cmp = 0;
   int           n_err = 0;
   int           step  = 0;

   power_alu #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .opcode (opcode),
      .a      (a),
`ifdef POWER_ALU_FLAGS_EN
      .zero   (zero),
      .neg    (neg),
      .carry  (carry),
      .ovf    (ovf),
`endif
      .b      (b)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver: inputs change on the falling edge, expected result queued with them
   task automatic drive(input logic rst, input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] exp);
      @(negedge clk);
      rst_n  = rst;
      opcode = op;
      a      = av;
      issue  = 1'b1;
      exp_q.push_back(exp);
   endtask

   // monitor: every edge that sampled an issued op produces one result on b
   always @(posedge clk) begin
      logic         taken;
      logic [W-1:0] exp;
      taken = issue;
      #1;
      if (taken) begin
         step++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL step%0d: result b=%02h with no expected entry", step, b);
         end else begin
            exp = exp_q.pop_front();
            if (b !== exp) begin
               n_err++;
               $display("FAIL step%0d: b=%02h expected %02h (op=%b a=%02h)",
                        step, b, exp, opcode, a);
            end
         end
      end
   end

   initial begin
      // reset holds b at 0 regardless of opcode/a
      drive(1'b0, 4'b0000, 8'd55,  8'h00);
      drive(1'b0, 4'b0010, 8'd55,  8'h00);
      drive(1'b1, 4'b0000, 8'd20,  8'd20);
      // add / subtract
      drive(1'b1, 4'b0010, 8'd10,  8'd30);
      drive(1'b1, 4'b0010, 8'd10,  8'd40);
      drive(1'b1, 4'b0011, 8'd10,  8'hE2);   // 10 - 40 = -30
      drive(1'b1, 4'b0000, 8'd1,   8'd1);
      drive(1'b1, 4'b0010, 8'd127, 8'h80);   // 127 + 1 wraps
      // increment / decrement / complement
      drive(1'b1, 4'b0001, 8'd127, 8'h80);
      drive(1'b1, 4'b0100, 8'h80,  8'h7F);   // -128 - 1 wraps
      drive(1'b1, 4'b0101, 8'hFB,  8'h04);   // ~(-5) = 4
      // bitwise
      drive(1'b1, 4'b0000, 8'hFF,  8'hFF);
      drive(1'b1, 4'b0110, 8'hFE,  8'hFE);
      drive(1'b1, 4'b0110, 8'hFC,  8'hFC);
      drive(1'b1, 4'b1000, 8'h10,  8'hFC);
      drive(1'b1, 4'b1010, 8'hFF,  8'h03);
      drive(1'b1, 4'b0111, 8'h0F,  8'hFC);   // ~(0F & 03)
      drive(1'b1, 4'b1001, 8'h01,  8'h02);   // ~(01 | FC)
      drive(1'b1, 4'b1011, 8'h06,  8'hFB);   // ~(06 ^ 02)
      // signed compare
      drive(1'b1, 4'b0000, 8'd5,   8'd5);
      drive(1'b1, 4'b1100, 8'hFB,  8'd0);    // -5 > 5 ? no
      drive(1'b1, 4'b1101, 8'hFB,  8'd1);    // -5 < 0 ? yes
      drive(1'b1, 4'b1110, 8'd1,   8'd1);
      drive(1'b1, 4'b1110, 8'd0,   8'd0);
      drive(1'b1, 4'b1110, 8'd0,   8'd1);
      drive(1'b1, 4'b1100, 8'd3,   8'd1);    // 3 > 1
      // logical NOT
      drive(1'b1, 4'b1111, 8'd0,   8'd1);
      drive(1'b1, 4'b1111, 8'hFB,  8'd0);
      // reset in mid-sequence, then resume from b = 0
      drive(1'b1, 4'b0000, 8'h33,  8'h33);
      drive(1'b0, 4'b0010, 8'd7,   8'h00);
      drive(1'b1, 4'b0010, 8'd7,   8'd7);
      drive(1'b1, 4'b0011, 8'd2,   8'hFB);   // 2 - 7 = -5
      @(negedge clk);
      issue = 1'b0;
      // bounded drain of any outstanding expectations
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d results still outstanding, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/power_alu.md
Name: power_alu

Overview:
- 8-bit signed accumulator-style ALU with 16 operations selected by a 4-bit opcode.
- Operand A is a primary input. Operand B is the registered result output, fed back internally.
- The result register updates once per rising clock edge.
- Used as a small datapath/compute element. There is no handshake: a new opcode/operand pair can be applied every cycle.

Parameters:
- WIDTH, 8, data width of a and b. All behaviour below is written for 8; it scales with WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- opcode  input  4  operation select
- a  input  8  signed operand A
- b  output  8  signed registered result; also serves as operand B

Behaviour:
- One clock. Reset is synchronous and active-low: on a rising clk edge with rst_n=0, b <= 0. Reset has priority over any opcode.
- Otherwise, on every rising clk edge, b <= f(opcode, a, b_current).
- Latency is one cycle: the result is visible after the edge at which the inputs were sampled. There is no enable; an operation executes every cycle.
- Arithmetic is 8-bit two's complement, modulo 2^8. Wrap-around is silent: 127+1 = -128, -128-1 = 127.
- Opcode map:
  - 0000 transfer: b <= a
  - 0001 increment: b <= a + 1
  - 0010 add: b <= a + b
  - 0011 subtract: b <= a - b
  - 0100 decrement: b <= a - 1
  - 0101 one's complement: b <= ~a
  - 0110 AND: b <= a & b
  - 0111 NAND: b <= ~(a & b)
  - 1000 OR: b <= a | b
  - 1001 NOR: b <= ~(a | b)
  - 1010 XOR: b <= a ^ b
  - 1011 XNOR: b <= ~(a ^ b)
  - 1100 greater-than: b <= (a > b) ? 1 : 0, signed compare
  - 1101 less-than: b <= (a < b) ? 1 : 0, signed compare
  - 1110 equal: b <= (a == b) ? 1 : 0
  - 1111 logical NOT: b <= (a == 0) ? 1 : 0
- Compare and logical results are zero-extended to 8 bits (00000001 or 00000000).
- All 16 opcodes are defined, so there are no illegal codes.
- Inputs that change mid-cycle have no effect until the next edge.
- If reset is asserted in the middle of a sequence, the next edge clears b to 0 regardless of opcode. Normal operation resumes on the first edge with rst_n=1, using b=0 as operand B.

Optional Feature:
- Macro POWER_ALU_FLAGS_EN.
- When defined, four registered outputs are added, each 1 bit wide and updated on the same edge as b:
  - zero: next b == 0
  - neg: next b[7]
  - carry: unsigned carry-out for add/increment; borrow for subtract/decrement; 0 for all other opcodes
  - ovf: signed overflow for add/sub/inc/dec; 0 for all other opcodes
- All four flags reset to 0.
- When not defined, these ports and their logic are absent, and b behaviour is identical in both builds.

Decomposition:
- Package power_alu_pkg holds:
  - WIDTH default
  - opcode enum: OP_PASS, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_NOT, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_GT, OP_LT, OP_EQ, OP_LNOT
- One combinational sub-module, power_alu_core, computes the next result (and flags) from opcode, a and b.
- The top level holds only the result/flag registers and reset.

Test Plan:
- Reset: hold rst_n=0 with opcode=0000, a=55 -> b=0. Release, apply a=20, opcode=0000 -> b=20.
- Add and subtract:
  - From b=20, opcode 0010 with a=10 -> b=30. Repeat -> b=40.
  - opcode 0011 with a=10 -> b=-30.
  - opcode 0010 with a=127 after loading b=1 -> b=-128 (wrap; ovf=1 with flags).
- Increment/decrement wrap:
  - opcode 0001 with a=127 -> b=-128.
  - opcode 0100 with a=-128 -> b=127.
  - opcode 0101 with a=-5 -> b=4.
- Bitwise:
  - Load b=-1 (0xFF), opcode 0110 with a=-2 -> 0xFE; then a=-4 -> 0xFC.
  - opcode 1000 with a=0x10 -> 0xFC.
  - opcode 1010 with a=-1 -> 0x03.
- Compare, signed:
  - Load b=5, opcode 1100 with a=-5 -> b=0.
  - Then opcode 1101 with a=-5 -> b=1.
  - Then opcode 1110 with a=1 -> b=1; a=0 -> b=0; a=0 again -> b=1.
- Logical NOT: opcode 1111 with a=0 -> b=1; with a=-5 -> b=0.
